// File: rtl/inst_buffer_pkg.sv
// Shared types and default sizing for the IFU-to-decode instruction buffer.
package inst_buffer_pkg;

   localparam int IB_DEPTH     = 16;
   localparam int FETCH_WIDTH  = 2;
   localparam int DECODE_WIDTH = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred_taken;
      logic [31:0] pred_target;
   } ib_entry_t;

endpackage

// File: rtl/inst_buffer_compact.sv
// Valid-lane compaction: each lane's write offset is the number of valid lanes below it.
module ib_compact #(
   parameter int LANES = 2,
   parameter int CW    = $clog2(LANES + 1)
) (
   input  logic [LANES-1:0]         valid,
   output logic [LANES-1:0][CW-1:0] offset,
   output logic [CW-1:0]            total
);

   logic [CW-1:0] acc;

   always_comb begin
      acc    = '0;
      offset = '0;
      for (int i = 0; i < LANES; i++) begin
         offset[i] = acc;
         acc       = acc + CW'(valid[i]);
      end
      total = acc;
   end

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer between IF3 and decode: multi-lane circular FIFO with one-cycle flush.
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH   = IB_DEPTH,
   parameter int FETCH_W = FETCH_WIDTH,
   parameter int DEC_W   = DECODE_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [FETCH_W-1:0]          in_valid,
   input  ib_entry_t [FETCH_W-1:0]     in_entry,
   output logic                        in_ready,
   output logic [DEC_W-1:0]            out_valid,
   output ib_entry_t [DEC_W-1:0]       out_entry,
   input  logic [DEC_W-1:0]            out_accept,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   localparam int CW   = $clog2(FETCH_W + 1);
   localparam int DW   = $clog2(DEC_W + 1);

   ib_entry_t                 storage [DEPTH];
   logic [PW-1:0]             head, tail;
   logic [CNTW-1:0]           free_slots;
   logic [FETCH_W-1:0][CW-1:0] wr_off;
   logic [CW-1:0]             nvalid;
   logic                      enq;
   logic [CW-1:0]             nenq;
   logic [DW-1:0]             ndeq;
   logic [DEC_W-1:0]          accept_inc;

   ib_compact #(.LANES(FETCH_W), .CW(CW)) u_compact (
      .valid  (in_valid),
      .offset (wr_off),
      .total  (nvalid)
   );

   // Credit only the registered occupancy; a same-cycle dequeue does not open space.
   assign free_slots = CNTW'(DEPTH) - count;
   assign in_ready   = free_slots >= CNTW'(FETCH_W);
   assign enq        = in_ready && (|in_valid);
   assign nenq       = enq ? nvalid : '0;

   for (genvar i = 0; i < DEC_W; i++) begin : g_out
      assign out_valid[i] = count > CNTW'(i);
      assign out_entry[i] = storage[head + PW'(i)];
   end

   always_comb begin
      ndeq = '0;
      for (int i = 0; i < DEC_W; i++)
         ndeq = ndeq + DW'(out_valid[i] & out_accept[i]);
   end

   always_ff @(posedge clk) begin
      if (enq && !flush && !rst) begin
         for (int i = 0; i < FETCH_W; i++)
            if (in_valid[i])
               storage[tail + PW'(wr_off[i])] <= in_entry[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         tail  <= tail + PW'(nenq);
         head  <= head + PW'(ndeq);
         count <= count + CNTW'(nenq) - CNTW'(ndeq);
      end
   end

   assign accept_inc = out_accept + DEC_W'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ((out_accept & accept_inc) == '0)
            else $error("inst_buffer: out_accept is not a prefix mask");
         assert (count <= CNTW'(DEPTH))
            else $error("inst_buffer: occupancy above depth");
      end
   end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed and random checks of inst_buffer against a queue-based reference model.
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 flush;
   logic [1:0]           in_valid;
   ib_entry_t [1:0]      in_entry;
   logic                 in_ready;
   logic [1:0]           out_valid;
   ib_entry_t [1:0]      out_entry;
   logic [1:0]           out_accept;
   logic [4:0]           count;

   int n_checks = 0;
   int n_fails  = 0;
   ib_entry_t q[$];

   inst_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_entry   (in_entry),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_entry  (out_entry),
      .out_accept (out_accept),
      .count      (count)
   );

   always #5 clk = ~clk;

   function automatic ib_entry_t mk(input logic [31:0] pc);
      ib_entry_t e;
      e.pc          = pc;
      e.inst        = ~pc;
      e.pred_taken  = pc[2];
      e.pred_target = pc + 32'h40;
      return e;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      int sz = q.size();
      check("count", 128'(count), 128'(sz));
      check("in_ready", 128'(in_ready), 128'((16 - sz) >= 2));
      for (int i = 0; i < 2; i++) begin
         check($sformatf("out_valid[%0d]", i), 128'(out_valid[i]), 128'(sz > i));
         if (sz > i)
            check($sformatf("out_entry[%0d]", i), 128'(out_entry[i]), 128'(q[i]));
      end
   endtask

   // Drive one cycle, advance the model by the buffer's rules, then check at the falling edge.
   task automatic step(input logic [1:0] v, input ib_entry_t e0, input ib_entry_t e1,
                       input logic [1:0] acc, input logic fl);
      int sz = q.size();
      int nd = 0;
      in_valid    = v;
      in_entry[0] = e0;
      in_entry[1] = e1;
      out_accept  = acc;
      flush       = fl;
      @(posedge clk);
      if (fl) q.delete();
      else begin
         for (int i = 0; i < 2; i++) if (acc[i] && sz > i) nd++;
         for (int i = 0; i < nd; i++) void'(q.pop_front());
         if ((16 - sz) >= 2) begin
            if (v[0]) q.push_back(e0);
            if (v[1]) q.push_back(e1);
         end
      end
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; in_valid = '0; out_accept = '0;
      in_entry[0] = mk(0); in_entry[1] = mk(0);
      repeat (2) @(posedge clk);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      check_model();
   endtask

   initial begin
      logic [1:0] v, a;
      // 1: reset then idle
      do_reset();
      check("reset_count", 128'(count), 128'(0));
      check("reset_out_valid", 128'(out_valid), 128'(0));
      check("reset_in_ready", 128'(in_ready), 128'(1));
      step(2'b00, mk(0), mk(0), 2'b00, 1'b0);

      // 2: two-lane enqueue
      step(2'b11, mk(32'h1000), mk(32'h1004), 2'b00, 1'b0);
      check("t2_pc0", 128'(out_entry[0].pc), 128'(32'h1000));
      check("t2_pc1", 128'(out_entry[1].pc), 128'(32'h1004));
      check("t2_count", 128'(count), 128'(2));

      // 3: lane-1-only enqueue into an empty buffer compacts to the head
      do_reset();
      step(2'b10, mk(32'h9999), mk(32'h2004), 2'b00, 1'b0);
      check("t3_out_valid", 128'(out_valid), 128'(2'b01));
      check("t3_pc0", 128'(out_entry[0].pc), 128'(32'h2004));

      // 4: fill to 15, full-ish buffer ignores fetch, one dequeue reopens it
      do_reset();
      for (int i = 0; i < 7; i++)
         step(2'b11, mk(32'h100 + 8*i), mk(32'h104 + 8*i), 2'b00, 1'b0);
      step(2'b01, mk(32'h1F0), mk(0), 2'b00, 1'b0);
      check("t4_count15", 128'(count), 128'(15));
      check("t4_not_ready", 128'(in_ready), 128'(0));
      step(2'b11, mk(32'hDEAD0), mk(32'hDEAD4), 2'b00, 1'b0);
      check("t4_ignored", 128'(count), 128'(15));
      step(2'b11, mk(32'hBEEF0), mk(32'hBEEF4), 2'b01, 1'b0);
      check("t4_count14", 128'(count), 128'(14));
      check("t4_ready", 128'(in_ready), 128'(1));

      // 5: pointers at 15, enqueue/dequeue across the wrap
      do_reset();
      for (int i = 0; i < 7; i++)
         step(2'b11, mk(32'h500 + 8*i), mk(32'h504 + 8*i), 2'b00, 1'b0);
      step(2'b01, mk(32'h5F0), mk(0), 2'b00, 1'b0);
      for (int i = 0; i < 7; i++) step(2'b00, mk(0), mk(0), 2'b11, 1'b0);
      step(2'b00, mk(0), mk(0), 2'b01, 1'b0);
      check("t5_empty", 128'(count), 128'(0));
      step(2'b11, mk(32'hA), mk(32'hB), 2'b00, 1'b0);
      check("t5_pc0", 128'(out_entry[0].pc), 128'(32'hA));
      check("t5_pc1", 128'(out_entry[1].pc), 128'(32'hB));
      step(2'b00, mk(0), mk(0), 2'b11, 1'b0);
      check("t5_drained", 128'(count), 128'(0));

      // 6: flush with traffic on both sides
      for (int i = 0; i < 4; i++)
         step(2'b11, mk(32'h700 + 8*i), mk(32'h704 + 8*i), 2'b00, 1'b0);
      step(2'b01, mk(32'h780), mk(0), 2'b00, 1'b0);
      check("t6_count9", 128'(count), 128'(9));
      step(2'b11, mk(32'h800), mk(32'h804), 2'b11, 1'b1);
      check("t6_flush_count", 128'(count), 128'(0));
      check("t6_flush_valid", 128'(out_valid), 128'(0));
      step(2'b01, mk(32'h3000), mk(0), 2'b00, 1'b0);
      check("t6_pc", 128'(out_entry[0].pc), 128'(32'h3000));

      // Random traffic with prefix accepts and occasional flushes
      for (int n = 0; n < 400; n++) begin
         v = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0:       a = 2'b00;
            1:       a = 2'b01;
            default: a = 2'b11;
         endcase
         step(v, mk($urandom), mk($urandom), a, ($urandom_range(0, 29) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
